// File: rtl/alu_uart_sequencer.sv
// Frame sequencer between a UART and an external ALU: collects operand A, operand B
// and an opcode byte, latches the ALU result and hands it to the transmitter.
module alu_uart_sequencer #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OPCODE      = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned NB_TIMER       = 20
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NB_DATA-1:0]   rx_data,
    input  logic                 rx_valid,
    input  logic [NB_DATA-1:0]   alu_result,
    input  logic                 tx_done,
    output logic [NB_DATA-1:0]   dato_a,
    output logic [NB_DATA-1:0]   dato_b,
    output logic [NB_OPCODE-1:0] opcode,
    output logic [NB_DATA-1:0]   tx_data,
    output logic                 tx_start,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 overrun_err
);

    localparam logic [NB_TIMER-1:0] TIMER_LAST = NB_TIMER'(TIMEOUT_CYCLES - 1);
    localparam logic [NB_TIMER-1:0] TIMER_ONE  = NB_TIMER'(1);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [NB_DATA-1:0]   dato_a_q, dato_a_d;
    logic [NB_DATA-1:0]   dato_b_q, dato_b_d;
    logic [NB_OPCODE-1:0] opcode_q, opcode_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic [NB_TIMER-1:0]  timer_q, timer_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 overrun_err_q, overrun_err_d;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d       = state_q;
        dato_a_d      = dato_a_q;
        dato_b_d      = dato_b_q;
        opcode_d      = opcode_q;
        tx_data_d     = tx_data_q;
        timer_d       = '0;
        timeout_err_d = 1'b0;
        overrun_err_d = overrun_err_q;

        case (state_q)
            GET_A: begin
                if (rx_valid) begin
                    dato_a_d = rx_data;
                    state_d  = GET_B;
                end
            end
            GET_B: begin
                if (rx_valid) begin
                    dato_b_d = rx_data;
                    state_d  = GET_OP;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = GET_A;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            GET_OP: begin
                if (rx_valid) begin
                    opcode_d = rx_data[NB_OPCODE-1:0];
                    state_d  = EXEC;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = GET_A;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            EXEC: begin
                tx_data_d = alu_result;
                state_d   = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_d = GET_A;
                end
            end
            default: begin
                state_d = GET_A;
            end
        endcase

        // Bytes arriving while a result is in flight are dropped but remembered
        if (rx_valid && (state_q == EXEC || state_q == SEND || state_q == WAIT_TX)) begin
            overrun_err_d = 1'b1;
        end

        tx_start_d = (state_d == SEND);
        busy_d     = (state_d == EXEC) || (state_d == SEND) || (state_d == WAIT_TX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= GET_A;
            dato_a_q      <= '0;
            dato_b_q      <= '0;
            opcode_q      <= '0;
            tx_data_q     <= '0;
            timer_q       <= '0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dato_a_q      <= dato_a_d;
            dato_b_q      <= dato_b_d;
            opcode_q      <= opcode_d;
            tx_data_q     <= tx_data_d;
            timer_q       <= timer_d;
            tx_start_q    <= tx_start_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign dato_a      = dato_a_q;
    assign dato_b      = dato_b_q;
    assign opcode      = opcode_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench for alu_uart_sequencer: stimulus queues expected results,
// a monitor checks every tx_start pulse for data and latency.
module tb_alu_uart_sequencer;

    localparam int unsigned NB_DATA   = 8;
    localparam int unsigned NB_OPCODE = 6;
    localparam int unsigned TMO       = 16;
    localparam int unsigned NB_TIMER  = 5;

    logic                 clock;
    logic                 reset;
    logic [NB_DATA-1:0]   rx_data;
    logic                 rx_valid;
    logic [NB_DATA-1:0]   alu_result;
    logic                 tx_done;
    logic [NB_DATA-1:0]   dato_a;
    logic [NB_DATA-1:0]   dato_b;
    logic [NB_OPCODE-1:0] opcode;
    logic [NB_DATA-1:0]   tx_data;
    logic                 tx_start;
    logic                 busy;
    logic                 timeout_err;
    logic                 overrun_err;

    alu_uart_sequencer #(
        .NB_DATA        (NB_DATA),
        .NB_OPCODE      (NB_OPCODE),
        .TIMEOUT_CYCLES (TMO),
        .NB_TIMER       (NB_TIMER)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .alu_result  (alu_result),
        .tx_done     (tx_done),
        .dato_a      (dato_a),
        .dato_b      (dato_b),
        .opcode      (opcode),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    // Bench ALU: ADD 0x20, SUB 0x22, AND 0x24
    always_comb begin
        case (opcode)
            6'h20:   alu_result = dato_a + dato_b;
            6'h22:   alu_result = dato_a - dato_b;
            6'h24:   alu_result = dato_a & dato_b;
            default: alu_result = '0;
        endcase
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   last_edge = 0;
    logic prev_start = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: every transmit request must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (tx_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL tx_start_unexpected: got pulse with tx_data=0x%0h, expected none (t=%0t)",
                             tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(e.data));
                    chk("tx_latency_edge", 32'(cyc), 32'(e.cyc));
                end
                chk("tx_start_single", 32'(prev_start), 32'd0);
            end
            prev_start = tx_start;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        last_edge = cyc;
        rx_valid  = 1'b0;
    endtask

    // Opcode accepted at edge N: tx_start is set by edge N+1 and seen before edge N+2
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] op, input logic [7:0] res);
        exp_t e;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        e.data = res;
        e.cyc  = last_edge + 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_tx_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (tx_start === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            $display("FAIL tx_start_wait: got no pulse in 20 cycles, expected one (t=%0t)", $time);
        end
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(posedge clock);
        #1;
        tx_done = 1'b0;
    endtask

    // Finish a transmission; optionally inject a byte while waiting on the transmitter
    task automatic finish_tx(input bit inject, input logic [7:0] exp_a);
        bit seen;
        wait_tx_start(seen);
        @(negedge clock);
        chk("busy_wait_tx", 32'(busy), 32'd1);
        if (inject) begin
            rx_data  = 8'hAA;
            rx_valid = 1'b1;
            @(posedge clock);
            #1;
            rx_valid = 1'b0;
            @(negedge clock);
            chk("overrun_set", 32'(overrun_err), 32'd1);
            chk("overrun_dato_a", 32'(dato_a), 32'(exp_a));
            chk("overrun_busy", 32'(busy), 32'd1);
        end
        pulse_done();
        @(negedge clock);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dato_a"}, 32'(dato_a), 32'd0);
        chk({tag, "_dato_b"}, 32'(dato_b), 32'd0);
        chk({tag, "_opcode"}, 32'(opcode), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        reset    = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_done  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        // Basic ADD frame
        send_frame(8'h05, 8'h03, 8'h20, 8'h08);
        chk("basic_dato_a", 32'(dato_a), 32'h05);
        chk("basic_dato_b", 32'(dato_b), 32'h03);
        chk("basic_opcode", 32'(opcode), 32'h20);
        chk("basic_busy_exec", 32'(busy), 32'd1);
        finish_tx(1'b0, 8'h00);

        // Back-to-back bytes, 8-bit wrap
        send_frame(8'hFF, 8'h01, 8'h20, 8'h00);
        finish_tx(1'b0, 8'h00);

        // SUB with tx_done coinciding with SEND, which must be ignored
        send_frame(8'h10, 8'h03, 8'h22, 8'h0D);
        @(negedge clock);
        @(negedge clock);
        pulse_done();
        @(negedge clock);
        chk("send_done_ignored_busy", 32'(busy), 32'd1);
        pulse_done();
        @(negedge clock);
        chk("send_done_release_busy", 32'(busy), 32'd0);

        // Timeout in GET_B after one byte
        send_byte(8'h11);
        repeat (TMO - 1) @(posedge clock);
        @(negedge clock);
        chk("timeout_not_early", 32'(timeout_err), 32'd0);
        @(negedge clock);
        chk("timeout_pulse", 32'(timeout_err), 32'd1);
        chk("timeout_dato_a_kept", 32'(dato_a), 32'h11);
        chk("timeout_busy", 32'(busy), 32'd0);
        @(negedge clock);
        chk("timeout_single", 32'(timeout_err), 32'd0);
        send_frame(8'h02, 8'h02, 8'h20, 8'h04);
        chk("after_timeout_dato_a", 32'(dato_a), 32'h02);
        finish_tx(1'b0, 8'h00);

        // Byte in the exact timeout cycle is accepted
        send_byte(8'h33);
        repeat (TMO - 1) @(posedge clock);
        send_byte(8'h46);
        @(negedge clock);
        chk("boundary_no_timeout", 32'(timeout_err), 32'd0);
        chk("boundary_dato_b", 32'(dato_b), 32'h46);
        begin
            exp_t e;
            send_byte(8'h24);
            e.data = 8'h02;
            e.cyc  = last_edge + 1;
            exp_q.push_back(e);
        end
        finish_tx(1'b0, 8'h00);

        // Overrun in WAIT_TX
        chk("overrun_clear_before", 32'(overrun_err), 32'd0);
        send_frame(8'h07, 8'h02, 8'h22, 8'h05);
        finish_tx(1'b1, 8'h07);
        send_frame(8'h09, 8'h04, 8'h22, 8'h05);
        chk("overrun_next_dato_a", 32'(dato_a), 32'h09);
        finish_tx(1'b0, 8'h00);
        chk("overrun_sticky", 32'(overrun_err), 32'd1);

        // Reset while waiting on the transmitter
        send_frame(8'h01, 8'h01, 8'h20, 8'h02);
        wait_tx_start(seen);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_all_zero("wait_tx_reset");
        repeat (10) @(negedge clock);
        send_frame(8'h03, 8'h04, 8'h20, 8'h07);
        finish_tx(1'b0, 8'h00);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
